// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation run controller and the mips top:
// run-state encoding and default datapath widths.
package sim_ctrl_pkg;

    localparam int DEFAULT_PC_W  = 32;
    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;

endpackage

// File: rtl/pc_halt_detector.sv
// Watches the sampled PC during RUN and strobes halt on a jump-to-self loop
// (HALT_REPEAT consecutive equal compares) or on an optional halt address.
module pc_halt_detector #(
    parameter int              PC_W        = 32,
    parameter int              HALT_REPEAT = 4,
    parameter bit              HALT_PC_EN  = 1'b0,
    parameter logic [PC_W-1:0] HALT_PC     = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            halt_o
);

    // One spare bit so the compare value HALT_REPEAT always fits.
    localparam int SAME_W = $clog2(HALT_REPEAT + 1) + 1;

    logic [PC_W-1:0]   prev_pc_q;
    logic              prev_valid_q;
    logic [SAME_W-1:0] same_cnt_q, same_cnt_d;

    always_comb begin
        same_cnt_d = '0;
        if (prev_valid_q && (pc_i == prev_pc_q)) begin
            same_cnt_d = same_cnt_q + SAME_W'(1);
        end
        halt_o = sample_i &&
                 ((same_cnt_d == SAME_W'(HALT_REPEAT)) ||
                  (HALT_PC_EN && (pc_i == HALT_PC)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            same_cnt_q   <= '0;
        end else if (sample_i) begin
            prev_pc_q    <= pc_i;
            prev_valid_q <= 1'b1;
            same_cnt_q   <= same_cnt_d;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Cycle-exact run controller for single-clock CPU simulation: programmable
// CPU reset, RUN cycle counting, PC-based halt detection and a watchdog.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int              PC_W        = DEFAULT_PC_W,
    parameter int              CNT_W       = DEFAULT_CNT_W,
    parameter int              RST_CYCLES  = 1,
    parameter int              MAX_CYCLES  = 50,
    parameter int              HALT_REPEAT = 4,
    parameter bit              HALT_PC_EN  = 1'b0,
    parameter logic [PC_W-1:0] HALT_PC     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic             finished,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  halt_pc,
    output run_state_e       dbg_state
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);

    run_state_e       state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic             halt;

    pc_halt_detector #(
        .PC_W       (PC_W),
        .HALT_REPEAT(HALT_REPEAT),
        .HALT_PC_EN (HALT_PC_EN),
        .HALT_PC    (HALT_PC)
    ) u_halt_det (
        .clk     (clk),
        .reset   (reset),
        .sample_i(state_q == ST_RUN),
        .pc_i    (pc),
        .halt_o  (halt)
    );

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cpu_reset_d = cpu_reset_q;
        running_d   = running_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        halt_pc_d   = halt_pc_q;
        cnt_next    = cnt_q + CNT_W'(1);
        case (state_q)
            ST_RST: begin
                rst_cnt_d = rst_cnt_q + RST_W'(1);
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d     = ST_RUN;
                    cpu_reset_d = 1'b0;
                    running_d   = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_next;
                // A halt on the watchdog edge wins over the timeout.
                if (halt) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    halt_pc_d = pc;
                    running_d = 1'b0;
                end else if (cnt_next == CNT_W'(MAX_CYCLES)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    running_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RST;
            rst_cnt_q   <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            halt_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            halt_pc_q   <= halt_pc_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign finished    = done_q | timeout_q;
    assign cycle_count = cnt_q;
    assign halt_pc     = halt_pc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomized bench for sim_run_ctrl: three differently parameterised
// instances share one reset/pc stream and are compared every cycle to a model.
module tb_sim_run_ctrl;

    localparam int N = 3;

    logic        clk;
    logic        reset_r;
    logic [31:0] pc_r;

    logic        cpu_reset_w [N];
    logic        running_w   [N];
    logic        done_w      [N];
    logic        timeout_w   [N];
    logic        finished_w  [N];
    logic [31:0] count_w     [N];
    logic [31:0] halt_pc_w   [N];
    logic [1:0]  state_w     [N];

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Instance parameters mirrored for the model.
    int          p_rst  [N];
    int          p_max  [N];
    int          p_rep  [N];
    bit          p_hen  [N];
    logic [31:0] p_hpc  [N];

    // Model state: edges since release, RUN pc history, sticky results.
    int          m_since [N];
    int          m_n     [N];
    logic [31:0] m_hist  [N][0:127];
    bit          m_done  [N];
    bit          m_to    [N];
    logic [31:0] m_cnt   [N];
    logic [31:0] m_hpc   [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sim_run_ctrl u_dut0 (
        .clk(clk), .reset(reset_r), .pc(pc_r),
        .cpu_reset(cpu_reset_w[0]), .running(running_w[0]), .done(done_w[0]),
        .timeout(timeout_w[0]), .finished(finished_w[0]),
        .cycle_count(count_w[0]), .halt_pc(halt_pc_w[0]), .dbg_state(state_w[0])
    );

    sim_run_ctrl #(.RST_CYCLES(3), .MAX_CYCLES(5), .HALT_REPEAT(2)) u_dut1 (
        .clk(clk), .reset(reset_r), .pc(pc_r),
        .cpu_reset(cpu_reset_w[1]), .running(running_w[1]), .done(done_w[1]),
        .timeout(timeout_w[1]), .finished(finished_w[1]),
        .cycle_count(count_w[1]), .halt_pc(halt_pc_w[1]), .dbg_state(state_w[1])
    );

    sim_run_ctrl #(.MAX_CYCLES(20), .HALT_REPEAT(2), .HALT_PC_EN(1'b1),
                   .HALT_PC(32'h0000_3010)) u_dut2 (
        .clk(clk), .reset(reset_r), .pc(pc_r),
        .cpu_reset(cpu_reset_w[2]), .running(running_w[2]), .done(done_w[2]),
        .timeout(timeout_w[2]), .finished(finished_w[2]),
        .cycle_count(count_w[2]), .halt_pc(halt_pc_w[2]), .dbg_state(state_w[2])
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_step(input int i, input bit rst, input logic [31:0] pcv);
        bit eq;
        bit halt;
        if (rst) begin
            m_since[i] = 0;
            m_n[i]     = 0;
            m_done[i]  = 0;
            m_to[i]    = 0;
            m_cnt[i]   = 0;
            m_hpc[i]   = 0;
        end else if (!m_done[i] && !m_to[i]) begin
            if (m_since[i] < p_rst[i]) begin
                m_since[i]++;
            end else begin
                m_hist[i][m_n[i]] = pcv;
                m_n[i]++;
                m_cnt[i] = m_n[i];
                // Loop halt: the newest HALT_REPEAT+1 RUN samples are all equal.
                eq = (m_n[i] > p_rep[i]);
                for (int t = 1; t <= p_rep[i]; t++) begin
                    if (eq && m_hist[i][m_n[i]-1-t] != pcv) eq = 0;
                end
                halt = eq || (p_hen[i] && pcv == p_hpc[i]);
                if (halt) begin
                    m_done[i] = 1;
                    m_hpc[i]  = pcv;
                end else if (m_n[i] == p_max[i]) begin
                    m_to[i] = 1;
                end
            end
        end
    endtask

    task automatic drive_cycle(input bit rst, input logic [31:0] pcv);
        bit in_run;
        logic [1:0] exp_state;
        reset_r = rst;
        pc_r    = pcv;
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i, rst, pcv);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            in_run = (m_since[i] >= p_rst[i]);
            exp_state = !in_run ? 2'd0 : m_done[i] ? 2'd2 : m_to[i] ? 2'd3 : 2'd1;
            check_eq($sformatf("u%0d.cpu_reset", i), 64'(cpu_reset_w[i]), 64'(!in_run));
            check_eq($sformatf("u%0d.running", i), 64'(running_w[i]),
                     64'(in_run && !m_done[i] && !m_to[i]));
            check_eq($sformatf("u%0d.done", i), 64'(done_w[i]), 64'(m_done[i]));
            check_eq($sformatf("u%0d.timeout", i), 64'(timeout_w[i]), 64'(m_to[i]));
            check_eq($sformatf("u%0d.finished", i), 64'(finished_w[i]),
                     64'(m_done[i] || m_to[i]));
            check_eq($sformatf("u%0d.cycle_count", i), 64'(count_w[i]), 64'(m_cnt[i]));
            check_eq($sformatf("u%0d.halt_pc", i), 64'(halt_pc_w[i]), 64'(m_hpc[i]));
            check_eq($sformatf("u%0d.state", i), 64'(state_w[i]), 64'(exp_state));
        end
    endtask

    initial begin
        int          mode;
        int          len;
        int          stick_at;
        logic [31:0] cur;

        p_rst = '{1, 3, 1};
        p_max = '{50, 5, 20};
        p_rep = '{4, 2, 2};
        p_hen = '{1'b0, 1'b0, 1'b1};
        p_hpc = '{32'h0, 32'h0, 32'h0000_3010};
        for (int i = 0; i < N; i++) model_step(i, 1'b1, 32'h0);

        reset_r = 1'b1;
        pc_r    = 32'h0;

        for (int ep = 0; ep < 40; ep++) begin
            len = $urandom_range(1, 2);
            for (int r = 0; r < len; r++) drive_cycle(1'b1, $urandom);

            // Episode 0: plain incrementing PC long enough for the watchdog.
            mode     = (ep == 0) ? 0 : $urandom_range(0, 2);
            len      = (ep == 0) ? 60 : $urandom_range(20, 75);
            stick_at = $urandom_range(2, 30);
            cur      = 32'h0000_3000;
            for (int c = 0; c < len; c++) begin
                drive_cycle((ep != 0) && ($urandom_range(0, 99) == 0), cur);
                case (mode)
                    0:       cur = cur + 32'd4;
                    1:       if (c < stick_at) cur = cur + 32'd4;
                    default: cur = 32'h0000_3000 + 32'(4 * $urandom_range(0, 4));
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
